// File: rtl/vblank_update_scheduler.sv
// vblank_update_scheduler: issues game updates at vblank,
// tracks completion, deadline overruns and skipped slots.
module vblank_update_scheduler #(
  parameter int X_ACTIVE  = 640,
  parameter int Y_ACTIVE  = 480,
  parameter int FRAME_DIV = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [9:0]       x_val,
  input  logic [9:0]       y_val,
  input  logic             game_enable,
  input  logic             update_done,
  input  logic             clear_overrun,
  output logic             video_on,
  output logic             frame_tick,
  output logic             update_start,
  output logic             updating,
  output logic             overrun,
  output logic [CNT_W-1:0] update_count,
  output logic [7:0]       overrun_count
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0] DIV_LAST = 4'(FRAME_DIV - 1);
  localparam logic [9:0] XA = 10'(X_ACTIVE);
  localparam logic [9:0] YA = 10'(Y_ACTIVE);

  state_t     state, state_n;
  logic [3:0] div;
  logic       late, late_n;
  logic       vb, dl, hit, slot;
  logic       start_n, done_ok, miss;

  assign vb   = (x_val == 10'd0) && (y_val == YA);
  assign dl   = (x_val == 10'd0) && (y_val == 10'd0);
  assign hit  = (div == DIV_LAST);
  assign slot = vb && hit && game_enable;

  assign updating = (state == BUSY);

  // Next state plus per-cycle start/complete/miss decisions
  always_comb begin
    state_n = state;
    late_n  = late;
    start_n = 1'b0;
    done_ok = 1'b0;
    miss    = 1'b0;
    unique case (state)
      IDLE: begin
        if (slot) begin
          state_n = BUSY;
          start_n = 1'b1;
          late_n  = 1'b0;
        end
      end
      BUSY: begin
        if (update_done) begin
          state_n = IDLE;
          done_ok = 1'b1;
        end else begin
          if (dl && !late) begin
            miss   = 1'b1;
            late_n = 1'b1;
          end
          if (slot) begin
            miss = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // FSM state and late-update marker
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      late  <= 1'b0;
    end else begin
      state <= state_n;
      late  <= late_n;
    end
  end

  // Frame divider: counts enabled vblanks, restarts when disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= 4'd0;
    end else if (!game_enable) begin
      div <= 4'd0;
    end else if (vb) begin
      div <= hit ? 4'd0 : div + 4'd1;
    end
  end

  // Registered raster outputs and update strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      video_on     <= 1'b0;
      frame_tick   <= 1'b0;
      update_start <= 1'b0;
    end else begin
      video_on     <= (x_val < XA) && (y_val < YA);
      frame_tick   <= vb;
      update_start <= start_n;
    end
  end

  // Completion and overrun bookkeeping; a new miss beats a clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      update_count  <= '0;
      overrun       <= 1'b0;
      overrun_count <= 8'd0;
    end else begin
      if (done_ok) begin
        update_count <= update_count + 1'b1;
      end
      if (miss) begin
        overrun <= 1'b1;
      end else if (clear_overrun) begin
        overrun <= 1'b0;
      end
      if (miss && overrun_count != 8'hFF) begin
        overrun_count <= overrun_count + 8'd1;
      end
    end
  end

endmodule

// File: doc/vblank_update_scheduler.md
Name: vblank_update_scheduler

Overview:
- Sequences game-logic updates against the 640x480 VGA raster; consumes the free-running horizontal/vertical counter values.
- Issues one update_start pulse per FRAME_DIV frames at the start of vertical blanking. Waits for update_done and flags overruns when an update runs past the next active frame.
- Also provides registered video_on and a per-frame frame_tick for renderer and game logic.

Parameters:
X_ACTIVE, 640, visible pixels per line; active when x_val < X_ACTIVE
Y_ACTIVE, 480, visible lines per frame; vblank event at y_val == Y_ACTIVE
FRAME_DIV, 1, an update is issued every FRAME_DIV-th vblank; legal range 1..16
CNT_W, 16, width of update_count

Ports:
clk  in  1  pixel clock, 25 MHz
rst_n  in  1  asynchronous active-low reset
x_val  in  10  current horizontal counter value
y_val  in  10  current vertical counter value
game_enable  in  1  level; 0 suppresses all update issue
update_done  in  1  one-cycle pulse from game logic; update finished
clear_overrun  in  1  one-cycle pulse; clears sticky overrun flag
video_on  out  1  registered active-video indicator
frame_tick  out  1  one-cycle pulse at every vblank event
update_start  out  1  one-cycle pulse; game logic begins update
updating  out  1  high while FSM is in BUSY
overrun  out  1  sticky; update missed its deadline or a slot was skipped
update_count  out  CNT_W  completed updates, wraps at 2^CNT_W
overrun_count  out  8  missed deadlines plus skipped slots, saturates at 255

Behaviour:
- Reset (rst_n low, async):
  - All outputs 0, FSM = IDLE, divider = 0.
  - Reset mid-update abandons it; a late update_done after reset release is ignored (FSM in IDLE).
- Events (combinational decode of inputs, acted on at next clk edge):
  - VB = (x_val == 0 && y_val == Y_ACTIVE)
  - DL (deadline) = (x_val == 0 && y_val == 0)
- video_on <= (x_val < X_ACTIVE) && (y_val < Y_ACTIVE); 1-cycle latency.
- frame_tick <= VB; 1-cycle latency, every frame regardless of game_enable.
- Divider div (4 bits):
  - On VB with game_enable=1: hit = (div == FRAME_DIV-1). div <= hit ? 0 : div+1.
  - game_enable=0 forces div <= 0.
- FSM states:
  - IDLE: on VB && hit && game_enable -> BUSY, update_start=1 for exactly that cycle (same cycle as frame_tick). Otherwise stay. update_done in IDLE is ignored.
  - BUSY: updating=1.
    - update_done -> IDLE, update_count += 1.
    - DL without update_done -> stay BUSY; overrun <= 1; overrun_count += 1 (saturating); late flag set so this update is counted at most once at DL.
    - VB && hit while BUSY -> no new update_start (slot skipped); overrun <= 1; overrun_count += 1 (saturating).
    - game_enable falling while BUSY does not abort; wait for update_done.
- Simultaneous events:
  - update_done with DL in the same cycle -> done wins; no overrun.
  - update_done with VB && hit in the same cycle (BUSY) -> return to IDLE this cycle, no skip counted. The slot is lost: the next update is issued at the following hit.
  - clear_overrun with a new overrun event in the same cycle -> set wins (overrun stays 1).
  - clear_overrun never clears overrun_count.
- Width rules:
  - update_count wraps modulo 2^CNT_W.
  - overrun_count holds at 255.
  - div compare uses FRAME_DIV-1 truncated to 4 bits.

Test Plan:
1. Reset: rst_n=0 mid-frame -> all outputs 0 immediately. Release, run 2 frames with game_enable=0 -> frame_tick pulses twice (one cycle each, 1 cycle after x=0,y=480), update_start never asserted.
2. FRAME_DIV=1, game_enable=1, update_done 1000 cycles after each update_start -> update_start once per frame, coincident with frame_tick; update_count=3 after 3 frames; overrun=0.
3. video_on: sweep x=639->640 on y=10 -> video_on drops one cycle after x=640 is presented. At y=479->480 it stays 0 for all x.
4. Deadline overrun: withhold update_done past x=0,y=0 -> overrun=1, overrun_count=1. Next VB skips update_start, overrun_count=2. Then update_done -> IDLE, update_count=1. clear_overrun -> overrun=0, overrun_count stays 2.
5. FRAME_DIV=3 -> update_start on the 3rd, 6th and 9th frame_tick only. Drop game_enable after the 4th tick, raise it before the 5th -> next update_start on the 7th tick (divider restarted).
6. Boundary: update_done in the same cycle as x=0,y=0 -> no overrun, update_count increments. Force 300 overruns -> overrun_count=255.
